// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT controller: default sizes, FSM
// state encoding and the bit-reverse helper used for load addressing.
package fft_pkg;

    localparam int FFT_ADDR_WIDTH = 5;
    localparam int FFT_BFLY_LAT   = 2;
    localparam int FFT_MAX_AW     = 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_READ       = 3'd2,
        S_CALC       = 3'd3,
        S_WRITE      = 3'd4,
        S_UNLOAD_RD  = 3'd5,
        S_UNLOAD_OUT = 3'd6
    } fft_state_e;

    // Reverses the low w bits of v; bits at or above w come back as zero.
    function automatic logic [FFT_MAX_AW-1:0] bit_reverse(
        input logic [FFT_MAX_AW-1:0] v,
        input int                    w
    );
        logic [FFT_MAX_AW-1:0] r;
        logic [FFT_MAX_AW-1:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < FFT_MAX_AW; i++) begin
            if (i < w) begin
                r = {r[FFT_MAX_AW-2:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_agu.sv
// Butterfly address generator: maps (stage, butterfly) to the two operand
// addresses and the twiddle ROM index of an in-place radix-2 DIT FFT.
module fft_agu
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = FFT_ADDR_WIDTH
) (
    input  logic [$clog2(ADDR_WIDTH+1)-1:0] stage,
    input  logic [ADDR_WIDTH-2:0]           butterfly,
    output logic [ADDR_WIDTH-1:0]           A_addr,
    output logic [ADDR_WIDTH-1:0]           B_addr,
    output logic [ADDR_WIDTH-2:0]           tw_addr
);

    localparam int STG_W = $clog2(ADDR_WIDTH + 1);
    localparam int TW_W  = ADDR_WIDTH - 1;

    logic [ADDR_WIDTH-1:0] w_b;
    logic [ADDR_WIDTH-1:0] w_span;
    logic [TW_W-1:0]       w_mask;
    logic [TW_W-1:0]       w_low;

    assign w_b    = {1'b0, butterfly};
    assign w_span = ADDR_WIDTH'(1) << stage;
    assign w_mask = TW_W'(w_span - ADDR_WIDTH'(1));
    assign w_low  = butterfly & w_mask;

    // A inserts a zero at bit 'stage' of the butterfly index; B sets it.
    assign A_addr  = ((w_b >> stage) << (stage + STG_W'(1))) | {1'b0, w_low};
    assign B_addr  = A_addr + w_span;
    assign tw_addr = w_low << (STG_W'(TW_W) - stage);

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 FFT sequencer: loads N samples in bit-reversed order,
// runs L stages of N/2 butterflies, then unloads results in natural order.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
    parameter int BFLY_LAT   = FFT_BFLY_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  roW,
    output logic                  singlewrite,
    output logic [ADDR_WIDTH-1:0] A_addr,
    output logic [ADDR_WIDTH-1:0] B_addr,
    output logic [ADDR_WIDTH-2:0] tw_addr,
    output logic                  wr_sel,
    output logic                  busy,
    output logic                  done
);

    localparam int STG_W = $clog2(ADDR_WIDTH + 1);
    localparam int LAT_W = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;

    localparam logic [STG_W-1:0]      STAGE_LAST = STG_W'(ADDR_WIDTH - 1);
    localparam logic [ADDR_WIDTH-2:0] BFLY_LAST  = '1;
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST   = '1;
    localparam logic [LAT_W-1:0]      LAT_LAST   = LAT_W'(BFLY_LAT - 1);

    fft_state_e            r_state;
    fft_state_e            w_next;
    logic [STG_W-1:0]      r_stage;
    logic [ADDR_WIDTH-2:0] r_bfly;
    logic [ADDR_WIDTH-1:0] r_lcnt;
    logic [ADDR_WIDTH-1:0] r_ucnt;
    logic [LAT_W-1:0]      r_lat;
    logic                  r_done;
    logic                  w_done_set;

    logic [ADDR_WIDTH-1:0] w_lrev;
    logic [ADDR_WIDTH-1:0] w_agu_a;
    logic [ADDR_WIDTH-1:0] w_agu_b;
    logic [ADDR_WIDTH-2:0] w_agu_tw;

    assign w_lrev = ADDR_WIDTH'(bit_reverse(FFT_MAX_AW'(r_lcnt), ADDR_WIDTH));

    fft_agu #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_agu (
        .stage     (r_stage),
        .butterfly (r_bfly),
        .A_addr    (w_agu_a),
        .B_addr    (w_agu_b),
        .tw_addr   (w_agu_tw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_bfly  <= '0;
            r_lcnt  <= '0;
            r_ucnt  <= '0;
            r_lat   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_done_set;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_stage <= '0;
                        r_bfly  <= '0;
                        r_lcnt  <= '0;
                        r_ucnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
                S_READ: begin
                    r_lat <= '0;
                end
                S_CALC: begin
                    r_lat <= r_lat + 1'b1;
                end
                S_WRITE: begin
                    // Stage wraps back to 0 after the final butterfly so the
                    // counters are clean for the next run.
                    if (r_bfly == BFLY_LAST) begin
                        r_bfly  <= '0;
                        r_stage <= (r_stage == STAGE_LAST) ? '0 : r_stage + 1'b1;
                    end else begin
                        r_bfly <= r_bfly + 1'b1;
                    end
                end
                S_UNLOAD_OUT: begin
                    if (out_ready) begin
                        r_ucnt <= r_ucnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next      = r_state;
        w_done_set  = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_idx     = '0;
        roW         = 1'b0;
        singlewrite = 1'b0;
        A_addr      = '0;
        B_addr      = '0;
        tw_addr     = '0;
        wr_sel      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready    = 1'b1;
                roW         = in_valid;
                singlewrite = in_valid;
                A_addr      = w_lrev;
                if (in_valid && (r_lcnt == IDX_LAST)) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                A_addr  = w_agu_a;
                B_addr  = w_agu_b;
                tw_addr = w_agu_tw;
                w_next  = S_CALC;
            end
            S_CALC: begin
                A_addr  = w_agu_a;
                B_addr  = w_agu_b;
                tw_addr = w_agu_tw;
                if (r_lat == LAT_LAST) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                roW     = 1'b1;
                wr_sel  = 1'b1;
                A_addr  = w_agu_a;
                B_addr  = w_agu_b;
                tw_addr = w_agu_tw;
                if ((r_bfly == BFLY_LAST) && (r_stage == STAGE_LAST)) begin
                    w_next = S_UNLOAD_RD;
                end else begin
                    w_next = S_READ;
                end
            end
            S_UNLOAD_RD: begin
                A_addr = r_ucnt;
                w_next = S_UNLOAD_OUT;
            end
            S_UNLOAD_OUT: begin
                out_valid = 1'b1;
                out_idx   = r_ucnt;
                A_addr    = r_ucnt;
                if (out_ready) begin
                    if (r_ucnt == IDX_LAST) begin
                        w_next     = S_IDLE;
                        w_done_set = 1'b1;
                    end else begin
                        w_next = S_UNLOAD_RD;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;

endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, giving point count N = 2^ADDR_WIDTH and stage count L = ADDR_WIDTH.
REQ-002 SHALL have parameter BFLY_LAT, default 2, giving butterfly compute cycles (minimum 1).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse that begins a load/compute/unload run; ignored unless IDLE.
REQ-006 in_valid / in_ready  in / out  1 / 1  sample-load handshake; sample data goes straight to the memory unit inputs.
REQ-007 out_valid / out_ready  out / in  1 / 1  result-unload handshake; data comes from the memory unit A port.
REQ-008 out_idx  out  ADDR_WIDTH  natural-order index of the sample presented with out_valid.
REQ-009 roW  out  1  memory unit mode: 0 = read, 1 = write.
REQ-010 singlewrite  out  1  memory unit writes A port only when 1.
REQ-011 A_addr, B_addr  out  ADDR_WIDTH  memory unit port addresses.
REQ-012 tw_addr  out  ADDR_WIDTH-1  twiddle ROM index for the current butterfly.
REQ-013 wr_sel  out  1  memory input mux: 0 = loader samples, 1 = butterfly results.
REQ-014 busy, done  out  1 each  busy = not IDLE; done = one-cycle pulse on return to IDLE after a completed run.

Function
REQ-015 SHALL implement states IDLE, LOAD, READ, CALC, WRITE, UNLOAD_RD, UNLOAD_OUT.
REQ-016 Transitions SHALL be:
- IDLE->LOAD on start.
- LOAD->READ after N accepted samples.
- READ->CALC.
- CALC->WRITE after BFLY_LAT cycles.
- WRITE->READ for the next butterfly, or WRITE->UNLOAD_RD after the last butterfly of stage L-1.
- UNLOAD_RD->UNLOAD_OUT.
- UNLOAD_OUT->UNLOAD_RD on an out_ready handshake with index < N-1, or ->IDLE with done on the handshake of index N-1.
REQ-017 LOAD SHALL drive:
- in_ready = 1, wr_sel = 0.
- roW = singlewrite = in_valid, combinationally.
- A_addr = bit-reverse(load count).
The load count SHALL increment only on in_valid & in_ready.
REQ-018 For stage s (0..L-1) and butterfly b (0..N/2-1), with span = 2^s:
- A_addr = ((b >> s) << (s+1)) | (b & (span-1)).
- B_addr = A_addr + span.
- tw_addr = (b & (span-1)) << (L-1-s).
REQ-019 These addresses SHALL stay constant through READ, CALC and WRITE of one butterfly.
REQ-020 Butterfly phase signals SHALL be:
- READ: roW = 0, singlewrite = 0.
- CALC: roW = 0.
- WRITE: roW = 1, singlewrite = 0, wr_sel = 1.
REQ-021 Each butterfly SHALL take exactly 2 + BFLY_LAT cycles; a full compute SHALL take L*(N/2)*(2+BFLY_LAT) cycles, with no gap between stages.
REQ-022 Butterfly index SHALL wrap N/2-1 -> 0 with stage increment; stage L-1 wrap ends compute.
REQ-023 UNLOAD_RD SHALL drive roW = 0 and A_addr = unload index.
REQ-024 UNLOAD_OUT SHALL hold out_valid = 1, out_idx = unload index and A_addr unchanged until out_ready; memory read data is valid one cycle after the read address.
REQ-025 A start pulse while busy SHALL be ignored. in_valid outside LOAD SHALL be ignored, with in_ready = 0.
REQ-026 roW SHALL never be 1 outside LOAD (with in_valid) and WRITE.

Reset
REQ-027 rst SHALL force IDLE and clear the stage, butterfly, load and unload counters from any state, including mid-compute.
REQ-028 While rst is high and in IDLE, all outputs SHALL be 0.

Structure
REQ-029 State encoding, the bit-reverse function and the ADDR_WIDTH/BFLY_LAT defaults SHALL live in shared package fft_pkg.
REQ-030 Address math SHALL be one combinational sub-module fft_agu (inputs: stage, butterfly; outputs: A_addr, B_addr, tw_addr); the FSM and counters stay in fft_ctrl.

Verification
REQ-031 Load: start, then 32 in_valid cycles with no stalls -> A_addr sequence 0,16,8,24,4,...,31, singlewrite = roW = 1 each cycle, then READ.
REQ-032 Addresses: stage 0 b = 0,1 -> (A,B,tw) = (0,1,0),(2,3,0); stage 2 b = 5 -> (9,13,4); stage 4 b = 15 -> (15,31,15).
REQ-033 Timing: with BFLY_LAT = 2, compute spans exactly 320 cycles from the first READ to the last WRITE; roW = 1 only in every 4th compute cycle.
REQ-034 Unload backpressure: hold out_ready low for 3 cycles at index 7 -> out_valid stays high, out_idx = 7 and A_addr = 7 are held; release -> index 8 is read next; done pulses once after index 31.
REQ-035 Reset mid-op: assert rst during stage 2 -> next cycle IDLE with all outputs 0; a new start begins LOAD with load count 0.
REQ-036 Spurious start while busy, and in_valid during compute -> no state, counter or memory-write change.
